exp_align: RTL and testbench

EXP_ALIGN -- requirements
Module: exp_align

---
 rtl/exp_align.sv | 161 ++++++++++++++++
 tb/tb_exp_align.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exp_align.sv
// ============================================================================
//  Module      : exp_align
//  Description : Two-stage floating-point exponent alignment pipeline.
//                Stage 1 compares the effective exponents and orders the
//                operands so the larger-exponent one is "big". Stage 2
//                right-shifts the small mantissa by the exponent difference,
//                saturating at the mantissa path width.
//                Valid/ready handshake on both sides, one result per cycle.
//  Options     : EXP_ALIGN_STICKY_EN - when defined, bit 0 of M_small also
//                collects the OR of every bit shifted out (sticky).
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module exp_align #(
   parameter int EXP_W  = 8,
   parameter int FRAC_W = 23
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [EXP_W+FRAC_W:0]     X,
   input  logic [EXP_W+FRAC_W:0]     Y,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic                      sgn_d,
   output logic [EXP_W-1:0]          E_max,
   output logic [FRAC_W+3:0]         M_big,
   output logic [FRAC_W+3:0]         M_small,
   output logic                      S_big,
   output logic                      S_small
);

   localparam int          c_OP_W = 1 + EXP_W + FRAC_W;
   localparam int          c_MW   = FRAC_W + 4;
   localparam logic [31:0] c_MW_U = c_MW;

   // ------------------------------------------------------------------------
   // Stage 1 operand decode and compare
   // ------------------------------------------------------------------------
   logic [EXP_W-1:0] w_ex_fld;
   logic [EXP_W-1:0] w_ey_fld;
   logic [EXP_W-1:0] w_ex_eff;
   logic [EXP_W-1:0] w_ey_eff;
   logic [c_MW-1:0]  w_mx;
   logic [c_MW-1:0]  w_my;
   logic [EXP_W:0]   w_d;
   logic             w_swap;
   logic [EXP_W:0]   w_dabs;

   assign w_ex_fld = X[FRAC_W +: EXP_W];
   assign w_ey_fld = Y[FRAC_W +: EXP_W];

   // A zero exponent field (subnormal/zero) behaves like exponent 1 with no hidden bit
   assign w_ex_eff = (w_ex_fld == '0) ? EXP_W'(1) : w_ex_fld;
   assign w_ey_eff = (w_ey_fld == '0) ? EXP_W'(1) : w_ey_fld;

   assign w_mx = {(|w_ex_fld), X[FRAC_W-1:0], 3'b000};
   assign w_my = {(|w_ey_fld), Y[FRAC_W-1:0], 3'b000};

   // Signed difference one bit wider than the exponent so it can never overflow
   assign w_d    = {1'b0, w_ex_eff} - {1'b0, w_ey_eff};
   assign w_swap = w_d[EXP_W];
   assign w_dabs = w_swap ? (-w_d) : w_d;

   // ------------------------------------------------------------------------
   // Handshake
   // ------------------------------------------------------------------------
   logic r_s1_valid;
   logic w_s2_adv;

   assign w_s2_adv = !out_valid || out_ready;
   assign in_ready = !r_s1_valid || w_s2_adv;

   // ------------------------------------------------------------------------
   // Stage 1 registers
   // ------------------------------------------------------------------------
   logic             r_s1_sgn;
   logic [EXP_W:0]   r_s1_dabs;
   logic [EXP_W-1:0] r_s1_emax;
   logic [c_MW-1:0]  r_s1_mbig;
   logic [c_MW-1:0]  r_s1_msml;
   logic             r_s1_sbig;
   logic             r_s1_ssml;

   // Capture the ordered operand pair whenever stage 1 can take new data
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_s1_valid <= 1'b0;
         r_s1_sgn   <= 1'b0;
         r_s1_dabs  <= '0;
         r_s1_emax  <= '0;
         r_s1_mbig  <= '0;
         r_s1_msml  <= '0;
         r_s1_sbig  <= 1'b0;
         r_s1_ssml  <= 1'b0;
      end else if (in_ready) begin
         r_s1_valid <= in_valid;
         if (in_valid) begin
            r_s1_sgn  <= w_swap;
            r_s1_dabs <= w_dabs;
            r_s1_emax <= w_swap ? w_ey_eff : w_ex_eff;
            r_s1_mbig <= w_swap ? w_my : w_mx;
            r_s1_msml <= w_swap ? w_mx : w_my;
            r_s1_sbig <= w_swap ? Y[c_OP_W-1] : X[c_OP_W-1];
            r_s1_ssml <= w_swap ? X[c_OP_W-1] : Y[c_OP_W-1];
         end
      end
   end

   // ------------------------------------------------------------------------
   // Stage 2 alignment shifter
   // ------------------------------------------------------------------------
   logic            w_sat;
   logic [c_MW-1:0] w_shifted;
   logic [c_MW-1:0] w_msml_out;

   // Differences at or beyond the path width push every bit out
   assign w_sat     = (32'(r_s1_dabs) >= c_MW_U);
   assign w_shifted = w_sat ? '0 : (r_s1_msml >> r_s1_dabs);

`ifdef EXP_ALIGN_STICKY_EN
   logic [c_MW-1:0] w_lost_mask;
   logic            w_sticky;

   // Mask selects exactly the low bits that fall off the right end
   assign w_lost_mask = ~({c_MW{1'b1}} << r_s1_dabs);
   assign w_sticky    = |(r_s1_msml & w_lost_mask);
   assign w_msml_out  = {w_shifted[c_MW-1:1], w_shifted[0] | w_sticky};
`else
   assign w_msml_out  = w_shifted;
`endif

   // Output register; holds its value while the consumer stalls
   always_ff @(posedge CLK) begin
      if (RST) begin
         out_valid <= 1'b0;
         sgn_d     <= 1'b0;
         E_max     <= '0;
         M_big     <= '0;
         M_small   <= '0;
         S_big     <= 1'b0;
         S_small   <= 1'b0;
      end else if (w_s2_adv) begin
         out_valid <= r_s1_valid;
         if (r_s1_valid) begin
            sgn_d   <= r_s1_sgn;
            E_max   <= r_s1_emax;
            M_big   <= r_s1_mbig;
            M_small <= w_msml_out;
            S_big   <= r_s1_sbig;
            S_small <= r_s1_ssml;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_exp_align.sv
// ============================================================================
//  Module      : tb_exp_align
//  Description : Self-checking bench for exp_align. A scoreboard queue holds
//                results computed arithmetically from each accepted operand
//                pair and is compared against every emitted result.
//                Honors EXP_ALIGN_STICKY_EN the same way as the design.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_exp_align;

   localparam int EW = 8;
   localparam int FW = 23;
   localparam int MW = FW + 4;
   localparam int OW = 1 + EW + FW;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [OW-1:0] x;
   logic [OW-1:0] y;
   logic          out_valid;
   logic          out_ready;
   logic          sgn_d;
   logic [EW-1:0] e_max;
   logic [MW-1:0] m_big;
   logic [MW-1:0] m_small;
   logic          s_big;
   logic          s_small;

   always #5 clk = ~clk;

   exp_align #(.EXP_W(EW), .FRAC_W(FW)) dut (
      .CLK       (clk),
      .RST       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .X         (x),
      .Y         (y),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sgn_d     (sgn_d),
      .E_max     (e_max),
      .M_big     (m_big),
      .M_small   (m_small),
      .S_big     (s_big),
      .S_small   (s_small)
   );

   typedef struct packed {
      logic          sgn;
      logic [EW-1:0] emax;
      logic [MW-1:0] mbig;
      logic [MW-1:0] msml;
      logic          sbig;
      logic          ssml;
   } res_t;

   res_t exp_q[$];
   int   checks = 0;
   int   failures = 0;
   int   n_accept = 0;
   int   n_emit = 0;
   res_t so;
   logic so_valid;
   logic so_in_ready;
   bit   prev_stall = 1'b0;
   res_t prev_out;

   task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic res_t mk(input logic s, input logic [EW-1:0] e, input logic [MW-1:0] mb,
                               input logic [MW-1:0] ms, input logic sb, input logic ss);
      res_t r;
      r.sgn = s; r.emax = e; r.mbig = mb; r.msml = ms; r.sbig = sb; r.ssml = ss;
      return r;
   endfunction

   function automatic res_t live();
      return mk(sgn_d, e_max, m_big, m_small, s_big, s_small);
   endfunction

   // Reference: plain integer arithmetic on the operand fields
   function automatic res_t model(input logic [OW-1:0] a, input logic [OW-1:0] b);
      res_t   r;
      int     ea, eb, efa, efb, d, sh;
      longint ma, mb, big, sml, shf;
`ifdef EXP_ALIGN_STICKY_EN
      bit     lost;
`endif
      ea  = int'(a[FW +: EW]);
      eb  = int'(b[FW +: EW]);
      efa = (ea == 0) ? 1 : ea;
      efb = (eb == 0) ? 1 : eb;
      ma  = ((ea != 0 ? longint'(1) << FW : longint'(0)) + longint'(a[FW-1:0])) * 8;
      mb  = ((eb != 0 ? longint'(1) << FW : longint'(0)) + longint'(b[FW-1:0])) * 8;
      d   = efa - efb;
      if (d < 0) begin
         r.sgn = 1'b1; r.emax = EW'(efb); big = mb; sml = ma;
         r.sbig = b[OW-1]; r.ssml = a[OW-1]; sh = -d;
      end else begin
         r.sgn = 1'b0; r.emax = EW'(efa); big = ma; sml = mb;
         r.sbig = a[OW-1]; r.ssml = b[OW-1]; sh = d;
      end
      shf = (sh >= MW) ? 0 : (sml >> sh);
`ifdef EXP_ALIGN_STICKY_EN
      lost = (sh >= MW) ? (sml != 0) : ((shf << sh) != sml);
      if (lost) shf = shf | 1;
`endif
      r.mbig = MW'(big);
      r.msml = MW'(shf);
      return r;
   endfunction

   function automatic logic [OW-1:0] rnd_op(input int base);
      logic [EW-1:0] e;
      int            k;
      k = $urandom_range(0, 7);
      if (k == 0)      e = '0;
      else if (k == 1) e = EW'($urandom);
      else             e = EW'(base + $urandom_range(0, 35));
      return {1'($urandom_range(0, 1)), e, FW'($urandom)};
   endfunction

   // One clock: drive after the falling edge, sample 1ns later, score, advance
   task automatic step(input logic r, input logic v, input logic [OW-1:0] a,
                       input logic [OW-1:0] b, input logic ordy);
      res_t cur;
      res_t e;
      rst = r; in_valid = v; x = a; y = b; out_ready = ordy;
      #1;
      cur = live();
      so = cur; so_valid = out_valid; so_in_ready = in_ready;
      if (prev_stall) begin
         check("stall_valid", 96'(out_valid), 96'(1));
         check("stall_data", 96'(cur), 96'(prev_out));
      end
      if (!r) begin
         if (out_valid && out_ready) begin
            check("queue_nonempty", 96'(exp_q.size() != 0), 96'(1));
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("result", 96'(cur), 96'(e));
            end
            n_emit++;
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(model(a, b));
            n_accept++;
         end
      end
      prev_stall = !r && out_valid && !out_ready;
      prev_out   = cur;
      @(posedge clk);
      if (r) begin
         exp_q.delete();
         prev_stall = 1'b0;
      end
      @(negedge clk);
   endtask

   task automatic directed(input string tag, input logic [OW-1:0] a, input logic [OW-1:0] b,
                           input res_t expv);
      step(0, 1, a, b, 1);
      step(0, 0, '0, '0, 1);
      check({tag, "_lat1"}, 96'(so_valid), 96'(0));
      step(0, 0, '0, '0, 1);
      check({tag, "_valid"}, 96'(so_valid), 96'(1));
      check(tag, 96'(so), 96'(expv));
   endtask

   task automatic drain(input string tag, input int budget);
      int c;
      c = 0;
      while (c < budget && (exp_q.size() != 0 || so_valid)) begin
         step(0, 0, '0, '0, 1);
         c++;
      end
      check(tag, 96'(exp_q.size()), 96'(0));
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "simulation timeout");
   end

   initial begin : stimulus
      logic [OW-1:0] px[3];
      logic [OW-1:0] py[3];
      int            idx, acc0, em0, a0, e0, c;
      logic          sticky_bit;
`ifdef EXP_ALIGN_STICKY_EN
      sticky_bit = 1'b1;
`else
      sticky_bit = 1'b0;
`endif
      rst = 1'b1; in_valid = 1'b0; x = '0; y = '0; out_ready = 1'b1;
      @(negedge clk);
      step(1, 1, 32'h3F800000, 32'h3F800000, 1);
      step(1, 0, '0, '0, 1);

      // Reset state
      step(0, 0, '0, '0, 1);
      check("rst_out_valid", 96'(so_valid), 96'(0));
      check("rst_outputs", 96'(so), 96'(0));
      check("rst_in_ready", 96'(so_in_ready), 96'(1));

      // Directed alignment cases
      directed("ex_lt_ey", 32'h3F800000, 32'h40000000,
               mk(1'b1, 8'h80, 27'h4000000, 27'h2000000, 1'b0, 1'b0));
      directed("no_shift", 32'h3FC00000, 32'h3F800000,
               mk(1'b0, 8'h7F, 27'h6000000, 27'h4000000, 1'b0, 1'b0));
      directed("sat_d30", 32'h4E800000, 32'h3F800001,
               mk(1'b0, 8'h9D, 27'h4000000, 27'(sticky_bit), 1'b0, 1'b0));
      directed("d24", 32'h4B800000, 32'h3F800000,
               mk(1'b0, 8'h97, 27'h4000000, 27'h0000004, 1'b0, 1'b0));
      directed("d26", 32'h4C800000, 32'h3F800001,
               mk(1'b0, 8'h99, 27'h4000000, 27'h0000001, 1'b0, 1'b0));
      directed("d27", 32'h4D000000, 32'h3F800000,
               mk(1'b0, 8'h9A, 27'h4000000, 27'(sticky_bit), 1'b0, 1'b0));
      directed("signs", 32'hC0000000, 32'h3F800000,
               mk(1'b0, 8'h80, 27'h4000000, 27'h2000000, 1'b1, 1'b0));
      directed("subnormal", 32'h00000001, 32'h00800000,
               mk(1'b0, 8'h01, 27'h0000008, 27'h4000000, 1'b0, 1'b0));

      // Backpressure: consumer stalls while three pairs are offered
      for (int i = 0; i < 3; i++) begin
         px[i] = rnd_op(110);
         py[i] = rnd_op(110);
      end
      idx = 0;
      for (int k = 0; k < 5; k++) begin
         acc0 = n_accept;
         step(0, idx < 3, px[idx < 3 ? idx : 0], py[idx < 3 ? idx : 0], 0);
         if (n_accept != acc0) idx++;
      end
      check("bp_accepted", 96'(idx), 96'(2));
      check("bp_in_ready", 96'(so_in_ready), 96'(0));
      em0 = n_emit;
      c = 0;
      while (c < 30 && !(idx == 3 && exp_q.size() == 0)) begin
         acc0 = n_accept;
         step(0, idx < 3, px[idx < 3 ? idx : 0], py[idx < 3 ? idx : 0], 1);
         if (n_accept != acc0) idx++;
         c++;
      end
      check("bp_all_accepted", 96'(idx), 96'(3));
      check("bp_emitted", 96'(n_emit - em0), 96'(3));
      drain("bp_drain", 10);

      // Reset in flight discards everything
      step(0, 1, rnd_op(100), rnd_op(100), 0);
      step(0, 1, rnd_op(100), rnd_op(100), 0);
      step(1, 1, rnd_op(100), rnd_op(100), 0);
      for (int k = 0; k < 3; k++) begin
         step(0, 0, '0, '0, 1);
         check("rst_mid_out_valid", 96'(so_valid), 96'(0));
         check("rst_mid_outputs", 96'(so), 96'(0));
         check("rst_mid_in_ready", 96'(so_in_ready), 96'(1));
      end
      px[0] = rnd_op(100);
      py[0] = rnd_op(100);
      directed("post_rst", px[0], py[0], model(px[0], py[0]));

      // Randomized traffic with random stalls
      a0 = n_accept;
      e0 = n_emit;
      for (int k = 0; k < 400; k++) begin
         step(0, $urandom_range(0, 3) != 0, rnd_op(100), rnd_op(100),
              $urandom_range(0, 9) < 7);
      end
      drain("rand_drain", 10);
      check("rand_count", 96'(n_accept - a0), 96'(n_emit - e0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
